// File: rtl/dpsram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving both ports of a dpsram instance.
// Port A writes incoming words; port B prefetches into a 2-entry output buffer.
module dpsram_fifo_ctrl #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [DEPTH_LOG+1:0]   level,
    output logic                   cs_a,
    output logic                   we_a,
    output logic [DEPTH_LOG-1:0]   ad_a,
    output logic [WIDTH-1:0]       wd_a,
    output logic                   cs_b,
    output logic                   we_b,
    output logic [DEPTH_LOG-1:0]   ad_b,
    input  logic [WIDTH-1:0]       rd_b
);

    localparam logic [DEPTH_LOG:0] MemFull = (DEPTH_LOG+1)'(DEPTH);

    logic [DEPTH_LOG:0] wr_ptr_q, rd_ptr_q, mem_cnt;
    logic               inflight_q;
    logic [1:0]         obuf_cnt_q, obuf_cnt_d, obuf_left;
    logic [WIDTH-1:0]   obuf0_q, obuf0_d, obuf1_q, obuf1_d;
    logic [2:0]         obuf_claim;
    logic               push, pop, rd_issue;

    assign mem_cnt  = wr_ptr_q - rd_ptr_q;
    assign in_ready = rst_n & (mem_cnt != MemFull);
    assign push     = in_valid & in_ready;
    assign out_valid = (obuf_cnt_q != 2'd0);
    assign out_data  = obuf0_q;
    assign pop       = out_valid & out_ready;

    // Slots already spoken for once this edge's pop and in-flight capture settle.
    assign obuf_claim = {1'b0, obuf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_issue   = rst_n & (mem_cnt != '0) & (obuf_claim < 3'd2);

    assign cs_a = push;
    assign we_a = push;
    assign ad_a = wr_ptr_q[DEPTH_LOG-1:0];
    assign wd_a = in_data;
    assign cs_b = rd_issue;
    assign we_b = 1'b0;
    assign ad_b = rd_ptr_q[DEPTH_LOG-1:0];

    assign level = {1'b0, mem_cnt} + (DEPTH_LOG+2)'(inflight_q) + (DEPTH_LOG+2)'(obuf_cnt_q);

    always_comb begin
        obuf0_d    = obuf0_q;
        obuf1_d    = obuf1_q;
        obuf_left  = obuf_cnt_q - {1'b0, pop};
        obuf_cnt_d = obuf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        if (pop) begin
            obuf0_d = obuf1_q;
        end
        // Capture lands behind whatever survives the pop, preserving order.
        if (inflight_q) begin
            if (obuf_left == 2'd0) begin
                obuf0_d = rd_b;
            end else begin
                obuf1_d = rd_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            obuf_cnt_q <= 2'd0;
            obuf0_q    <= '0;
            obuf1_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            inflight_q <= rd_issue;
            obuf_cnt_q <= obuf_cnt_d;
            obuf0_q    <= obuf0_d;
            obuf1_q    <= obuf1_d;
        end
    end

endmodule

// File: tb/tb_dpsram_fifo_ctrl.sv
// Directed bench for dpsram_fifo_ctrl with a behavioural dpsram (1-cycle read latency).
module tb_dpsram_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int DL    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [DL+1:0]    level;
    logic             cs_a, we_a, cs_b, we_b;
    logic [DL-1:0]    ad_a, ad_b;
    logic [WIDTH-1:0] wd_a, rd_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dpsram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .cs_a(cs_a), .we_a(we_a), .ad_a(ad_a), .wd_a(wd_a),
        .cs_b(cs_b), .we_b(we_b), .ad_b(ad_b), .rd_b(rd_b)
    );

    // Behavioural dpsram: synchronous write on A, registered read on B.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (cs_a && we_a) mem[ad_a] <= wd_a;
        if (cs_b && !we_b) rd_b <= mem[ad_b];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Port discipline, sampled mid-cycle once inputs are settled.
    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;
    initial begin : port_monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wr_cnt = 0;
                rd_cnt = 0;
            end else begin
                n_cmp++;
                if (we_b !== 1'b0) begin
                    n_err++; $display("FAIL port_we_b got %b want 0", we_b);
                end
                if (cs_a) begin
                    n_cmp++;
                    if (we_a !== 1'b1 || ad_a !== wr_cnt[DL-1:0]) begin
                        n_err++;
                        $display("FAIL port_a we_a=%b ad_a=%0d want we_a=1 ad_a=%0d",
                                 we_a, ad_a, wr_cnt[DL-1:0]);
                    end
                end
                if (cs_b) begin
                    n_cmp++;
                    if (wr_cnt == rd_cnt || ad_b !== rd_cnt[DL-1:0]) begin
                        n_err++;
                        $display("FAIL port_b ad_b=%0d stored=%0d want ad_b=%0d stored>0",
                                 ad_b, wr_cnt - rd_cnt, rd_cnt[DL-1:0]);
                    end
                end
                if (cs_a && cs_b) begin
                    n_cmp++;
                    if (ad_a === ad_b) begin
                        n_err++; $display("FAIL port_collide ad_a=%0d ad_b=%0d want differ", ad_a, ad_b);
                    end
                end
                if (cs_a) wr_cnt = wr_cnt + 1;
                if (cs_b) rd_cnt = rd_cnt + 1;
            end
        end
    end

    task automatic test_reset();
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || level !== '0 || in_ready !== 1'b0 ||
            cs_a !== 1'b0 || cs_b !== 1'b0 || we_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state ov=%b od=%h lvl=%0d ir=%b csa=%b csb=%b web=%b want all 0",
                     out_valid, out_data, level, in_ready, cs_a, cs_b, we_b);
        end
        in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || cs_a !== 1'b0) begin
            n_err++; $display("FAIL reset_push_blocked ir=%b csa=%b want 0 0", in_ready, cs_a);
        end
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || level !== '0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release ir=%b lvl=%0d ov=%b want 1 0 0", in_ready, level, out_valid);
        end
    endtask

    task automatic test_latency();
        in_valid  = 1'b1;
        in_data   = 32'h20;
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if (cs_a !== 1'b1 || ad_a !== 3'd0 || wd_a !== 32'h20) begin
            n_err++; $display("FAIL lat_write csa=%b ada=%0d wda=%h want 1 0 20", cs_a, ad_a, wd_a);
        end
        step();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (cs_b !== 1'b1 || ad_b !== 3'd0 || level !== 5'd1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lat_issue csb=%b adb=%0d lvl=%0d ov=%b want 1 0 1 0", cs_b, ad_b, level, out_valid);
        end
        step();
        n_cmp++;
        if (cs_b !== 1'b0 || out_valid !== 1'b0 || level !== 5'd1) begin
            n_err++; $display("FAIL lat_inflight csb=%b ov=%b lvl=%0d want 0 0 1", cs_b, out_valid, level);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h20 || level !== 5'd1) begin
            n_err++;
            $display("FAIL lat_out ov=%b od=%h lvl=%0d want 1 20 1", out_valid, out_data, level);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            n_err++; $display("FAIL lat_pop ov=%b lvl=%0d want 0 0", out_valid, level);
        end
    endtask

    task automatic test_fill_drain();
        int acc = 0;
        int k = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(32'h20 + acc);
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (acc != DEPTH + 2 || in_ready !== 1'b0 || level !== 5'(DEPTH + 2)) begin
            n_err++;
            $display("FAIL fill_capacity acc=%0d ir=%b lvl=%0d want 10 0 10", acc, in_ready, level);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                n_cmp++;
                if (out_data !== 32'(32'h20 + k)) begin
                    n_err++; $display("FAIL drain_data got %h want %h", out_data, 32'h20 + k);
                end
                k++;
            end
            step();
        end
        out_ready = 1'b0;
        n_cmp++;
        if (k != DEPTH + 2 || level !== 5'd0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL drain_end words=%0d lvl=%0d ov=%b want 10 0 0", k, level, out_valid);
        end
    endtask

    task automatic test_streaming();
        int pushed = 0;
        int popped = 0;
        for (int i = 0; i < 50; i++) begin
            in_valid  = (pushed < 40);
            in_data   = 32'(32'h100 + pushed);
            out_ready = 1'b1;
            if (in_valid) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_err++; $display("FAIL stream_in_ready cycle %0d got %b want 1", i, in_ready);
                end
            end
            if (popped > 0 && popped < 40) begin
                n_cmp++;
                if (out_valid !== 1'b1) begin
                    n_err++; $display("FAIL stream_gap cycle %0d ov=%b want 1", i, out_valid);
                end
            end
            if (out_valid) begin
                n_cmp++;
                if (out_data !== 32'(32'h100 + popped)) begin
                    n_err++; $display("FAIL stream_data got %h want %h", out_data, 32'h100 + popped);
                end
                popped++;
            end
            if (in_valid && in_ready) pushed++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (popped != 40 || level !== 5'd0) begin
            n_err++; $display("FAIL stream_end popped=%0d lvl=%0d want 40 0", popped, level);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] q[$];
        logic [WIDTH-1:0] exp_w;
        for (int i = 0; i < 2030; i++) begin
            if (i >= 2000 && q.size() == 0) break;
            n_cmp++;
            if (level !== 5'(q.size())) begin
                n_err++; $display("FAIL bp_level cycle %0d got %0d want %0d", i, level, q.size());
            end
            in_valid  = (i < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data   = $urandom;
            out_ready = (i < 2000) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL bp_extra got %h want no word", out_data);
                end else begin
                    exp_w = q.pop_front();
                    if (out_data !== exp_w) begin
                        n_err++; $display("FAIL bp_data got %h want %h", out_data, exp_w);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(in_data);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (q.size() != 0 || level !== 5'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_end left=%0d lvl=%0d ov=%b want 0 0 0", q.size(), level, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        int acc = 0;
        bit seen = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (acc < 6);
            in_data  = 32'(32'hA0 + acc);
            if (in_valid && in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        in_valid  = 1'b1;
        in_data   = 32'hEE;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (level !== 5'd6 || cs_a !== 1'b1 || cs_b !== 1'b1 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre lvl=%0d csa=%b csb=%b ov=%b want 6 1 1 1", level, cs_a, cs_b, out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (cs_a !== 1'b0 || cs_b !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
            level !== 5'd0) begin
            n_err++;
            $display("FAIL mid_reset csa=%b csb=%b ir=%b ov=%b lvl=%0d want 0 0 0 0 0",
                     cs_a, cs_b, in_ready, out_valid, level);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || level !== 5'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_release ir=%b lvl=%0d ov=%b want 1 0 0", in_ready, level, out_valid);
        end
        in_valid = 1'b1;
        in_data  = 32'h55;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                n_cmp++;
                if (out_data !== 32'h55) begin
                    n_err++; $display("FAIL mid_first_word got %h want 00000055", out_data);
                end
            end
            step();
        end
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL mid_timeout got no word want 00000055");
        end
        step();
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            n_err++; $display("FAIL mid_stale ov=%b lvl=%0d want 0 0", out_valid, level);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_drain();
        test_streaming();
        test_backpressure();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
